// File: rtl/iob_ram_dp_be_copy.sv
// iob_ram_dp_be_copy
//   Block copy / block fill engine that drives a dual-port byte-enable RAM
//   (read-first, one-cycle registered read). Port A reads the source range,
//   port B writes the destination range, one word per cycle.
//
// Ports
//   clk_i, rst_n_i        clock, synchronous active-low reset
//   start_i, fill_i       request and mode (1 = fill, 0 = copy), sampled in IDLE
//   src_addr_i            first source word address (copy mode)
//   dst_addr_i            first destination word address
//   len_i                 word count, 0 .. 2**ADDR_W
//   wstrb_i               byte mask applied to every destination write
//   fill_data_i           constant word for fill mode
//   busy_o, done_o        transfer in progress / one-cycle completion pulse
//   enA_o..dA_o, dA_i     RAM port A (read only; write controls held at 0)
//   enB_o..dB_o           RAM port B (write)
module iob_ram_dp_be_copy #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  start_i,
   input  logic                  fill_i,
   input  logic [ADDR_W-1:0]     src_addr_i,
   input  logic [ADDR_W-1:0]     dst_addr_i,
   input  logic [ADDR_W:0]       len_i,
   input  logic [DATA_W/8-1:0]   wstrb_i,
   input  logic [DATA_W-1:0]     fill_data_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  enA_o,
   output logic [DATA_W/8-1:0]   weA_o,
   output logic [ADDR_W-1:0]     addrA_o,
   output logic [DATA_W-1:0]     dA_o,
   input  logic [DATA_W-1:0]     dA_i,
   output logic                  enB_o,
   output logic [DATA_W/8-1:0]   weB_o,
   output logic [ADDR_W-1:0]     addrB_o,
   output logic [DATA_W-1:0]     dB_o
);

   localparam int STRB_W = DATA_W / 8;

   localparam logic [ADDR_W:0]   CNT_ONE  = 1;
   localparam logic [ADDR_W:0]   CNT_TWO  = 2;
   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t              state_q;
   logic                fill_q;
   logic [STRB_W-1:0]   wstrb_q;
   logic [DATA_W-1:0]   fill_data_q;
   logic [ADDR_W:0]     cnt_q;        // words still to issue, including the current one
   logic                enA_q;
   logic [ADDR_W-1:0]   addrA_q;
   logic                enB_q;
   logic [ADDR_W-1:0]   addrB_q;
   logic                busy_q;
   logic                done_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         fill_q      <= 1'b0;
         wstrb_q     <= '0;
         fill_data_q <= '0;
         cnt_q       <= '0;
         enA_q       <= 1'b0;
         addrA_q     <= '0;
         enB_q       <= 1'b0;
         addrB_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  fill_q      <= fill_i;
                  wstrb_q     <= wstrb_i;
                  fill_data_q <= fill_data_i;
                  cnt_q       <= len_i;
                  addrB_q     <= dst_addr_i;
                  busy_q      <= 1'b1;
                  if (!fill_i) addrA_q <= src_addr_i;
                  if (len_i == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= RUN;
                     enA_q   <= !fill_i;
                     enB_q   <= fill_i;
                     // fill of a single word completes in its only write cycle
                     done_q  <= fill_i && (len_i == CNT_ONE);
                  end
               end
            end
            RUN: begin
               if (fill_q) begin
                  if (cnt_q == CNT_ONE) begin
                     state_q <= IDLE;
                     enB_q   <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b0;
                  end else begin
                     cnt_q   <= cnt_q - CNT_ONE;
                     addrB_q <= addrB_q + ADDR_ONE;
                     done_q  <= (cnt_q == CNT_TWO);
                  end
               end else begin
                  // write side trails the read side by the RAM read latency
                  enB_q <= 1'b1;
                  if (enB_q) addrB_q <= addrB_q + ADDR_ONE;
                  if (cnt_q == CNT_ONE) begin
                     state_q <= DRAIN;
                     enA_q   <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     cnt_q   <= cnt_q - CNT_ONE;
                     addrA_q <= addrA_q + ADDR_ONE;
                  end
               end
            end
            DRAIN: begin
               state_q <= IDLE;
               enB_q   <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o  = busy_q;
   assign done_o  = done_q;
   assign enA_o   = enA_q;
   assign weA_o   = '0;
   assign addrA_o = addrA_q;
   assign dA_o    = '0;
   assign enB_o   = enB_q;
   assign weB_o   = enB_q ? wstrb_q : '0;
   assign addrB_o = addrB_q;
   // copy data is the RAM read word passed straight through
   assign dB_o    = !enB_q ? '0 : (fill_q ? fill_data_q : dA_i);

endmodule

// File: tb/tb_iob_ram_dp_be_copy.sv
// Testbench for iob_ram_dp_be_copy: behavioural read-first RAM, table of
// transfer vectors, write/read scoreboards and hand-written reset,
// len=0 and ignored-start sequences.
module tb_iob_ram_dp_be_copy;

   localparam int AW   = 10;
   localparam int DW   = 32;
   localparam int SW   = DW / 8;
   localparam int MEMN = 1 << AW;

   logic            clk = 1'b0;
   logic            rst_n_i;
   logic            start_i;
   logic            fill_i;
   logic [AW-1:0]   src_addr_i;
   logic [AW-1:0]   dst_addr_i;
   logic [AW:0]     len_i;
   logic [SW-1:0]   wstrb_i;
   logic [DW-1:0]   fill_data_i;
   logic            busy_o, done_o;
   logic            enA_o, enB_o;
   logic [SW-1:0]   weA_o, weB_o;
   logic [AW-1:0]   addrA_o, addrB_o;
   logic [DW-1:0]   dA_o, dA_i, dB_o;

   always #5 clk = ~clk;

   iob_ram_dp_be_copy #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_i(clk), .rst_n_i(rst_n_i), .start_i(start_i), .fill_i(fill_i),
      .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
      .wstrb_i(wstrb_i), .fill_data_i(fill_data_i), .busy_o(busy_o),
      .done_o(done_o), .enA_o(enA_o), .weA_o(weA_o), .addrA_o(addrA_o),
      .dA_o(dA_o), .dA_i(dA_i), .enB_o(enB_o), .weB_o(weB_o),
      .addrB_o(addrB_o), .dB_o(dB_o)
   );

   // behavioural RAM: read-first, registered read on A, byte-enable write on B
   logic [DW-1:0] mem [MEMN];
   logic [DW-1:0] ramA_q;
   assign dA_i = ramA_q;

   always @(posedge clk) begin
      if (enA_o) ramA_q <= mem[addrA_o];
      if (enB_o)
         for (int b = 0; b < SW; b++)
            if (weB_o[b]) mem[addrB_o][b*8 +: 8] = dB_o[b*8 +: 8];
   end

   typedef struct {
      logic          fill;
      logic [AW-1:0] src;
      logic [AW-1:0] dst;
      logic [AW:0]   len;
      logic [SW-1:0] wstrb;
      logic [DW-1:0] fd;
      logic          ovl;
      int            exp_done;
      int            exp_busy;
      int            exp_ena;
      int            exp_enb;
   } vec_t;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [SW-1:0] s;
   } wr_t;

   wr_t            wq[$];
   logic [AW-1:0]  rq[$];
   logic [DW-1:0]  snap    [MEMN];
   logic [DW-1:0]  exp_mem [MEMN];
   vec_t           vecs [9];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                           input logic [SW-1:0] s);
      logic [DW-1:0] r;
      r = old;
      for (int b = 0; b < SW; b++)
         if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
      return r;
   endfunction

   task automatic preload();
      for (int i = 0; i < MEMN; i++) mem[i] = 32'hA000_0000 + i;
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge of the
   // cycle after done_o, so a following call starts back-to-back.
   task automatic run_vec(input int id, input vec_t v);
      int k, done_at, nbusy, na, nb, zviol, bad, budget;
      logic [AW-1:0] a, sa;
      logic [DW-1:0] d;
      wr_t w;
      preload();
      if (v.ovl)
         for (int i = 0; i < 3; i++) begin
            sa = v.src + AW'(i);
            mem[sa] = DW'(i + 1);
         end
      for (int i = 0; i < MEMN; i++) begin
         snap[i] = mem[i];
         exp_mem[i] = mem[i];
      end
      wq.delete();
      rq.delete();
      for (int i = 0; i < int'(v.len); i++) begin
         a  = v.dst + AW'(i);
         sa = v.src + AW'(i);
         d  = v.fill ? v.fd : snap[sa];
         w.a = a; w.d = d; w.s = v.wstrb;
         wq.push_back(w);
         if (!v.fill) rq.push_back(sa);
         exp_mem[a] = merge(exp_mem[a], d, v.wstrb);
      end
      chk($sformatf("v%0d_pre_busy", id), busy_o, 0);
      start_i = 1'b1; fill_i = v.fill; src_addr_i = v.src; dst_addr_i = v.dst;
      len_i = v.len; wstrb_i = v.wstrb; fill_data_i = v.fd;
      k = 0; done_at = 0; nbusy = 0; na = 0; nb = 0; zviol = 0;
      budget = int'(v.len) + 8;
      while (done_at == 0 && k < budget) begin
         @(negedge clk);
         k++;
         if (k == 1) begin
            start_i = 1'b0;
            chk($sformatf("v%0d_first_rd", id), enA_o, (!v.fill && v.len != 0) ? 1 : 0);
         end
         if (busy_o) nbusy++;
         if (done_o) done_at = k;
         if (enA_o) begin
            na++;
            if (rq.size() == 0) chk($sformatf("v%0d_rd_extra", id), 1, 0);
            else begin
               a = rq.pop_front();
               chk($sformatf("v%0d_rd_addr", id), addrA_o, a);
            end
         end
         if (enB_o) begin
            nb++;
            if (wq.size() == 0) chk($sformatf("v%0d_wr_extra", id), 1, 0);
            else begin
               w = wq.pop_front();
               chk($sformatf("v%0d_wr_addr", id), addrB_o, w.a);
               chk($sformatf("v%0d_wr_data", id), dB_o, w.d);
               chk($sformatf("v%0d_wr_strb", id), weB_o, w.s);
            end
         end else if (weB_o != '0 || dB_o != '0) zviol++;
         if (weA_o != '0 || dA_o != '0) zviol++;
      end
      chk($sformatf("v%0d_done_cycle", id), done_at, v.exp_done);
      chk($sformatf("v%0d_busy_cycles", id), nbusy, v.exp_busy);
      chk($sformatf("v%0d_enA_cycles", id), na, v.exp_ena);
      chk($sformatf("v%0d_enB_cycles", id), nb, v.exp_enb);
      chk($sformatf("v%0d_zero_outputs", id), zviol, 0);
      @(negedge clk);
      chk($sformatf("v%0d_post_busy", id), busy_o, 0);
      chk($sformatf("v%0d_post_done", id), done_o, 0);
      chk($sformatf("v%0d_post_en", id), {enA_o, enB_o}, 0);
      chk($sformatf("v%0d_queues_empty", id), wq.size() + rq.size(), 0);
      bad = 0;
      for (int i = 0; i < MEMN; i++) if (mem[i] !== exp_mem[i]) bad++;
      chk($sformatf("v%0d_mem_words_wrong", id), bad, 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_done"}, done_o, 0);
      chk({tag, "_enA"}, enA_o, 0);
      chk({tag, "_enB"}, enB_o, 0);
      chk({tag, "_weB"}, weB_o, 0);
      chk({tag, "_addrA"}, addrA_o, 0);
      chk({tag, "_addrB"}, addrB_o, 0);
      chk({tag, "_weA_dA"}, {weA_o, dA_o}, 0);
   endtask

   initial begin
      int dseen;
      rst_n_i = 1'b0; start_i = 1'b0; fill_i = 1'b0; src_addr_i = '0;
      dst_addr_i = '0; len_i = '0; wstrb_i = '0; fill_data_i = '0;
      preload();
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst_n_i = 1'b1;
      @(negedge clk);

      vecs[0] = '{1'b0, 10'h010, 10'h100, 11'd4,    4'hF, 32'h0,         1'b0, 5, 5, 4, 4};
      vecs[1] = '{1'b1, 10'h000, 10'h3FE, 11'd4,    4'h3, 32'hDEADBEEF,  1'b0, 4, 4, 0, 4};
      vecs[2] = '{1'b0, 10'h005, 10'h105, 11'd0,    4'hF, 32'h0,         1'b0, 1, 1, 0, 0};
      vecs[3] = '{1'b0, 10'h020, 10'h021, 11'd3,    4'hF, 32'h0,         1'b1, 4, 4, 3, 3};
      vecs[4] = '{1'b0, 10'h3FD, 10'h200, 11'd5,    4'h5, 32'h0,         1'b0, 6, 6, 5, 5};
      vecs[5] = '{1'b0, 10'h040, 10'h050, 11'd3,    4'h0, 32'h0,         1'b0, 4, 4, 3, 3};
      vecs[6] = '{1'b1, 10'h000, 10'h010, 11'd1,    4'hF, 32'h12345678,  1'b0, 1, 1, 0, 1};
      vecs[7] = '{1'b0, 10'h0AA, 10'h0BB, 11'd1,    4'hC, 32'h0,         1'b0, 2, 2, 1, 1};
      vecs[8] = '{1'b1, 10'h000, 10'h123, 11'd1024, 4'hF, 32'h5A5AA5A5,  1'b0, 1024, 1024, 0, 1024};

      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      // len=0, then a start with len=8 during the busy cycle must be dropped
      start_i = 1'b1; fill_i = 1'b0; src_addr_i = '0; dst_addr_i = 10'h080;
      len_i = '0; wstrb_i = 4'hF;
      @(negedge clk);
      chk("len0_busy", busy_o, 1);
      chk("len0_done", done_o, 1);
      chk("len0_en", {enA_o, enB_o}, 0);
      len_i = 11'd8;
      @(negedge clk);
      start_i = 1'b0;
      chk("ign_busy", busy_o, 0);
      chk("ign_en", {enA_o, enB_o}, 0);
      @(negedge clk);
      chk("ign_busy2", busy_o, 0);
      chk("ign_en2", {enA_o, enB_o}, 0);

      // reset in the middle of a 16-word copy
      preload();
      start_i = 1'b1; fill_i = 1'b0; src_addr_i = '0; dst_addr_i = 10'h300;
      len_i = 11'd16; wstrb_i = 4'hF;
      dseen = 0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 1) start_i = 1'b0;
         if (done_o) dseen++;
         if (k == 5) rst_n_i = 1'b0;
         if (k == 6) begin
            chk_reset_vals("midrst");
            rst_n_i = 1'b1;
         end
      end
      chk("midrst_no_done", dseen, 0);
      for (int i = 0; i < 4; i++)
         chk($sformatf("midrst_partial%0d", i), mem[10'h300 + i], 32'hA000_0000 + i);
      chk("midrst_untouched", mem[10'h304], 32'hA000_0304);
      run_vec(9, vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
